mem_load_ctrl: RTL and testbench
================================

Name: mem_load_ctrl

Overview:
- Sequencer and arbiter in front of the 32-bit byte-loadable register memory.
- Accepts whole 32-bit words from two requesters over valid/ready, with round-robin arbitration.
- Breaks each word into four byte-write cycles on the memory's MEM_LOAD / MEM_IN / MEM_LOAD_VAL interface, honouring a per-byte mask.
- Also issues single-cycle memory clears on request.

Parameters:
- LSB_FIRST, 1: byte order of the load sequence. 1 = lanes 0,1,2,3; 0 = lanes 3,2,1,0.

Ports:
- clk  in  1  system clock, rising edge
- rst_CTRL  in  1  asynchronous, active-high reset
- REQ0_VALID  in  1  requester 0 has a word
- REQ0_DATA  in  32  requester 0 word
- REQ0_MASK  in  4  requester 0 byte enables; bit i covers DATA[8i+7:8i]
- REQ0_READY  out  1  requester 0 accepted this cycle
- REQ1_VALID, REQ1_DATA, REQ1_MASK, REQ1_READY  same as requester 0
- CLR_REQ  in  1  clear request; level, held until CLR_ACK
- CLR_ACK  out  1  one-cycle acknowledge of the clear
- MEM_LOAD  out  1  byte write enable to memory
- MEM_IN  out  8  byte to memory
- MEM_LOAD_VAL  out  2  byte lane select to memory
- rst_MEM  out  1  synchronous clear strobe to memory
- BUSY  out  1  controller not in IDLE
- GRANT  out  1  requester index of the current or most recent transfer
- DONE  out  1  one-cycle pulse on the last byte cycle of a transfer

Behaviour:
- Reset (async, immediate):
  - State = IDLE, byte counter = 0, round-robin pointer = "last granted 1", so REQ0 wins the first tie.
  - MEM_LOAD, MEM_IN, MEM_LOAD_VAL, rst_MEM, CLR_ACK, DONE, BUSY and GRANT are all 0.
  - An in-flight transfer is abandoned; no further bytes are issued.
- Registered outputs: MEM_*, rst_MEM, CLR_ACK, DONE, GRANT and BUSY are registered. REQx_READY is combinational.
- States: IDLE, LOAD, CLEAR.
- IDLE:
  - If CLR_REQ = 1, go to CLEAR. Clear has priority and both READYs stay 0.
  - Otherwise, if any VALID is high, the arbiter picks a winner and asserts its READY only. The loser's READY = 0.
  - Handshake = VALID & READY at a rising edge. At that edge: latch DATA and MASK, set GRANT, go to LOAD.
- Arbitration:
  - With a single valid requester, that requester wins.
  - With both valid, the requester not granted last wins.
  - The pointer updates only on a handshake.
- LOAD (4 cycles, handshake edge T):
  - Cycles T+1..T+4 each present one lane k in sequence order.
  - In each cycle: MEM_LOAD_VAL = k, MEM_IN = latched byte k, MEM_LOAD = latched MASK[k].
  - When the lane is masked off, MEM_IN still carries the byte but MEM_LOAD = 0.
  - DONE = 1 in cycle T+4 only. State returns to IDLE at the end of T+4.
- Throughput and timing:
  - A new handshake is possible at the end of T+5, so back-to-back words give a 5-cycle period.
  - The first byte of the next word appears at T+6.
  - MASK = 0000 still takes 4 cycles with MEM_LOAD low throughout, and DONE still pulses.
- CLEAR:
  - Lasts exactly 1 cycle, with rst_MEM = 1 and CLR_ACK = 1. Then return to IDLE.
  - If CLR_REQ is still high on return to IDLE, a new clear is started. The requester must drop CLR_REQ in the ACK cycle.
- Inputs arriving mid-operation:
  - CLR_REQ or VALID asserted during LOAD is not accepted until IDLE.
  - A pending clear wins over pending words at that IDLE.
- Other rules:
  - In IDLE, MEM_LOAD = 0 and rst_MEM = 0. MEM_IN and MEM_LOAD_VAL hold their last values.
  - BUSY = 1 in LOAD and CLEAR.
  - Requesters must hold VALID and DATA/MASK stable until READY.

Test Plan:
- Reset then single word: REQ0 sends 0xDEADBEEF with mask 1111, LSB_FIRST = 1.
  - Required: MEM_LOAD_VAL 0,1,2,3 carrying bytes EF, BE, AD, DE, MEM_LOAD = 1 in T+1..T+4, DONE in T+4.
  - Required: a memory model reads 0xDEADBEEF.
- Masked word: memory preloaded with 0x11223344, then REQ1 sends 0xAABBCCDD with mask 0101.
  - Required: MEM_LOAD high only for lanes 0 and 2.
  - Required: memory reads 0x11BB33DD.
- Contention: REQ0 and REQ1 both valid continuously after reset.
  - Required: grants alternate 0,1,0,1 with a 5-cycle handshake spacing.
  - Required: READY is never high for both requesters in the same cycle.
- Clear priority: CLR_REQ and REQ0_VALID rise in the same IDLE cycle.
  - Required: rst_MEM and CLR_ACK high for one cycle first, REQ0 accepted the following cycle.
  - Required: memory reads 0x00000000, then REQ0's word.
- Reset mid-operation: assert rst_CTRL during the 2nd byte cycle of 0xCAFEF00D.
  - Required: all outputs go 0 immediately and no further MEM_LOAD pulses occur.
  - Required: after release, the first tie goes to REQ0.
- Reverse order, LSB_FIRST = 0: REQ0 sends 0x01020304.
  - Required: MEM_LOAD_VAL 3,2,1,0 carrying bytes 01, 02, 03, 04, with DONE on the lane-0 cycle.

Source files
------------

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: round-robin word arbiter feeding four byte writes
// into a byte-loadable register memory, plus single-cycle clears.
module mem_load_ctrl #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_CTRL,
  input  logic        REQ0_VALID,
  input  logic [31:0] REQ0_DATA,
  input  logic [3:0]  REQ0_MASK,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ1_DATA,
  input  logic [3:0]  REQ1_MASK,
  output logic        REQ1_READY,
  input  logic        CLR_REQ,
  output logic        CLR_ACK,
  output logic        MEM_LOAD,
  output logic [7:0]  MEM_IN,
  output logic [1:0]  MEM_LOAD_VAL,
  output logic        rst_MEM,
  output logic        BUSY,
  output logic        GRANT,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        mem_load_q, mem_load_d;
  logic [7:0]  mem_in_q, mem_in_d;
  logic [1:0]  mem_val_q, mem_val_d;
  logic        rst_mem_q, rst_mem_d;
  logic        clr_ack_q, clr_ack_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        grant_q, grant_d;

  logic        pick;
  logic        idle_open;
  logic        hs;
  logic [31:0] src_data;
  logic [3:0]  src_mask;
  logic [1:0]  seq_idx;
  logic [1:0]  lane;

  always_comb begin
    pick = (REQ0_VALID & REQ1_VALID) ? ~last_q : REQ1_VALID;
    idle_open = (state_q == IDLE) & ~CLR_REQ;
  end

  assign REQ0_READY = idle_open & REQ0_VALID & ~pick;
  assign REQ1_READY = idle_open & REQ1_VALID & pick;
  assign hs = REQ0_READY | REQ1_READY;

  // Lane 0 of the sequence leaves on the handshake edge, straight from
  // the requester, so the word occupies exactly four output cycles.
  always_comb begin
    if (state_q == IDLE) begin
      src_data = pick ? REQ1_DATA : REQ0_DATA;
      src_mask = pick ? REQ1_MASK : REQ0_MASK;
      seq_idx  = 2'd0;
    end else begin
      src_data = data_q;
      src_mask = mask_q;
      seq_idx  = cnt_q;
    end
    lane = LSB_FIRST ? seq_idx : 2'd3 - seq_idx;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mem_load_d = 1'b0;
    mem_in_d   = mem_in_q;
    mem_val_d  = mem_val_q;
    rst_mem_d  = 1'b0;
    clr_ack_d  = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d   = CLEAR;
          rst_mem_d = 1'b1;
          clr_ack_d = 1'b1;
          busy_d    = 1'b1;
        end else if (hs) begin
          state_d    = LOAD;
          data_d     = src_data;
          mask_d     = src_mask;
          grant_d    = pick;
          last_d     = pick;
          busy_d     = 1'b1;
          cnt_d      = 2'd1;
          mem_val_d  = lane;
          mem_in_d   = src_data[{lane, 3'b000} +: 8];
          mem_load_d = src_mask[lane];
        end
      end
      LOAD: begin
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 2'd0;
        end else begin
          mem_val_d  = lane;
          mem_in_d   = src_data[{lane, 3'b000} +: 8];
          mem_load_d = src_mask[lane];
          cnt_d      = cnt_q + 2'd1;
          done_d     = (cnt_q == 2'd3);
        end
      end
      CLEAR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_CTRL) begin
    if (rst_CTRL) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 1'b1;
      data_q     <= 32'd0;
      mask_q     <= 4'd0;
      mem_load_q <= 1'b0;
      mem_in_q   <= 8'd0;
      mem_val_q  <= 2'd0;
      rst_mem_q  <= 1'b0;
      clr_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      mem_load_q <= mem_load_d;
      mem_in_q   <= mem_in_d;
      mem_val_q  <= mem_val_d;
      rst_mem_q  <= rst_mem_d;
      clr_ack_q  <= clr_ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign MEM_LOAD     = mem_load_q;
  assign MEM_IN       = mem_in_q;
  assign MEM_LOAD_VAL = mem_val_q;
  assign rst_MEM      = rst_mem_q;
  assign CLR_ACK      = clr_ack_q;
  assign DONE         = done_q;
  assign BUSY         = busy_q;
  assign GRANT        = grant_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb_mem_load_ctrl: scoreboard bench driving an LSB-first and an
// MSB-first controller in lockstep, each with its own memory model.
module tb_mem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [3:0]  m0 = '0, m1 = '0;
  logic        clr = 1'b0;

  logic [1:0]  rdy0, rdy1, ack, ld, rm, busy, gnt, done;
  logic [7:0]  min [2];
  logic [1:0]  lv [2];

  always #5 clk = ~clk;

  mem_load_ctrl #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_CTRL(rst),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_MASK(m0),
    .REQ0_READY(rdy0[0]),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_MASK(m1),
    .REQ1_READY(rdy1[0]),
    .CLR_REQ(clr), .CLR_ACK(ack[0]),
    .MEM_LOAD(ld[0]), .MEM_IN(min[0]),
    .MEM_LOAD_VAL(lv[0]), .rst_MEM(rm[0]),
    .BUSY(busy[0]), .GRANT(gnt[0]), .DONE(done[0])
  );

  mem_load_ctrl #(.LSB_FIRST(1'b0)) dut_r (
    .clk(clk), .rst_CTRL(rst),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_MASK(m0),
    .REQ0_READY(rdy0[1]),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_MASK(m1),
    .REQ1_READY(rdy1[1]),
    .CLR_REQ(clr), .CLR_ACK(ack[1]),
    .MEM_LOAD(ld[1]), .MEM_IN(min[1]),
    .MEM_LOAD_VAL(lv[1]), .rst_MEM(rm[1]),
    .BUSY(busy[1]), .GRANT(gnt[1]), .DONE(done[1])
  );

  typedef struct packed {
    logic       clr;
    logic [1:0] lane;
    logic [7:0] b;
    logic       ld;
    logic       dn;
    logic       g;
  } rec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
  } word_t;

  int errors = 0;
  int checks = 0;

  rec_t        expq0[$], expq1[$];
  logic [31:0] memq0[$], memq1[$];
  word_t       wq0[$], wq1[$];
  logic [31:0] tbmem [2];
  logic [31:0] refm [2];
  logic [31:0] prevm [2];
  int          hs_cyc[$];
  int          win_seq[$];
  bit          hs_seen [2];
  bit          act [2];
  int          clr_cnt = 0;
  bit          clr_act = 1'b0;
  event        hs_ev;

  function automatic void chk(input string nm,
                              input logic [31:0] a,
                              input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  function automatic void push_rec(input int i, input rec_t r);
    if (i == 0) expq0.push_back(r);
    else expq1.push_back(r);
  endfunction

  function automatic void push_mem(input int i, input logic [31:0] w);
    if (i == 0) memq0.push_back(w);
    else memq1.push_back(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++)
      if (m[l]) r[8*l +: 8] = w[8*l +: 8];
    return r;
  endfunction

  // Reference model: one word = four output cycles, one clear = one.
  initial begin
    int busy_left;
    bit last;
    int cyc;
    bit idle, er0, er1, w;
    logic [31:0] cd;
    logic [3:0]  cm;
    bit cur_word;
    rec_t r;
    busy_left = 0;
    last = 1'b1;
    cyc = 0;
    cur_word = 1'b0;
    cd = '0;
    cm = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        if (cur_word && busy_left > 0) begin
          for (int i = 0; i < 2; i++) begin
            refm[i] = prevm[i];
            for (int k = 0; k < 4 - busy_left; k++) begin
              int l;
              l = (i == 0) ? k : 3 - k;
              if (cm[l]) refm[i][8*l +: 8] = cd[8*l +: 8];
            end
          end
        end
        busy_left = 0;
        last = 1'b1;
        cur_word = 1'b0;
        expq0.delete();
        expq1.delete();
        memq0.delete();
        memq1.delete();
      end else begin
        cyc++;
        idle = (busy_left == 0);
        er0 = idle && !clr && v0 && (!v1 || last);
        er1 = idle && !clr && v1 && (!v0 || !last);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("ready0_dut%0d", i), rdy0[i], er0);
          chk($sformatf("ready1_dut%0d", i), rdy1[i], er1);
          chk($sformatf("ready_excl_dut%0d", i),
              rdy0[i] & rdy1[i], 0);
        end
        if (v0 && rdy0[0]) hs_seen[0] = 1'b1;
        if (v1 && rdy1[0]) hs_seen[1] = 1'b1;
        if (!idle) begin
          busy_left--;
        end else if (clr) begin
          r = '0;
          r.clr = 1'b1;
          for (int i = 0; i < 2; i++) begin
            push_rec(i, r);
            push_mem(i, 32'd0);
            refm[i] = 32'd0;
          end
          busy_left = 1;
          cur_word = 1'b0;
        end else if (er0 || er1) begin
          w = er1;
          cd = w ? d1 : d0;
          cm = w ? m1 : m0;
          for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
              int l;
              l = (i == 0) ? k : 3 - k;
              r.clr = 1'b0;
              r.lane = 2'(l);
              r.b = cd[8*l +: 8];
              r.ld = cm[l];
              r.dn = (k == 3);
              r.g = w;
              push_rec(i, r);
            end
            prevm[i] = refm[i];
            refm[i] = merge(refm[i], cd, cm);
            push_mem(i, refm[i]);
          end
          last = w;
          busy_left = 4;
          cur_word = 1'b1;
          hs_cyc.push_back(cyc);
          win_seq.push_back(int'(w));
          ->hs_ev;
        end
      end
    end
  end

  // Memory device models, one per controller.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rm[i]) tbmem[i] = 32'd0;
        else if (ld[i]) tbmem[i][8*lv[i] +: 8] = min[i];
        if (rm[i] || done[i]) begin
          if ((i == 0 ? memq0.size() : memq1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected_dut%0d: got %0h", i,
                     tbmem[i]);
          end else begin
            e = (i == 0) ? memq0.pop_front() : memq1.pop_front();
            chk($sformatf("mem_dut%0d", i), tbmem[i], e);
          end
        end
      end
    end
  end

  // Output monitor: every BUSY cycle consumes one expected record.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          if (busy[i]) begin
            if ((i == 0 ? expq0.size() : expq1.size()) == 0) begin
              checks++;
              errors++;
              $display("FAIL busy_unexpected_dut%0d: got 1 want 0",
                       i);
            end else begin
              e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
              if (e.clr)
                chk($sformatf("clr_cycle_dut%0d", i),
                    {rm[i], ack[i], ld[i], done[i]}, 4'b1100);
              else
                chk($sformatf("byte_cycle_dut%0d", i),
                    {rm[i], ack[i], ld[i], done[i], lv[i],
                     min[i], gnt[i]},
                    {2'b00, e.ld, e.dn, e.lane, e.b, e.g});
            end
          end else begin
            chk($sformatf("idle_out_dut%0d", i),
                {ld[i], rm[i], ack[i], done[i]}, 4'b0000);
          end
        end
      end
    end
  end

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (act[0] && hs_seen[0]) begin
        hs_seen[0] = 1'b0;
        act[0] = 1'b0;
        v0 = 1'b0;
      end
      if (!act[0] && wq0.size() > 0 && !rst) begin
        w = wq0.pop_front();
        d0 = w.d;
        m0 = w.m;
        v0 = 1'b1;
        act[0] = 1'b1;
      end
    end
  end

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (act[1] && hs_seen[1]) begin
        hs_seen[1] = 1'b0;
        act[1] = 1'b0;
        v1 = 1'b0;
      end
      if (!act[1] && wq1.size() > 0 && !rst) begin
        w = wq1.pop_front();
        d1 = w.d;
        m1 = w.m;
        v1 = 1'b1;
        act[1] = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (clr_act && ack[0]) begin
        clr = 1'b0;
        clr_act = 1'b0;
      end else if (!clr_act && clr_cnt > 0 && !rst) begin
        clr = 1'b1;
        clr_act = 1'b1;
        clr_cnt--;
      end
    end
  end

  task automatic wait_idle(input string nm, input int lim);
    int n;
    n = 0;
    while (!(wq0.size() == 0 && wq1.size() == 0 && !act[0] &&
             !act[1] && clr_cnt == 0 && !clr_act &&
             expq0.size() == 0 && expq1.size() == 0 &&
             busy == 2'b00) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: waited %0d cycles", nm, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string nm);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_dut%0d", nm, i),
          {ld[i], min[i], lv[i], rm[i], ack[i], done[i],
           busy[i], gnt[i]}, 0);
  endtask

  initial begin
    word_t w;
    for (int i = 0; i < 2; i++) begin
      tbmem[i] = '0;
      refm[i] = '0;
      prevm[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    wq0.push_back({32'hDEADBEEF, 4'b1111});
    wait_idle("single", 100);
    for (int i = 0; i < 2; i++)
      chk($sformatf("single_mem_dut%0d", i), tbmem[i],
          32'hDEADBEEF);

    for (int i = 0; i < 2; i++) begin
      tbmem[i] = 32'h11223344;
      refm[i] = 32'h11223344;
    end
    wq1.push_back({32'hAABBCCDD, 4'b0101});
    wait_idle("masked", 100);
    for (int i = 0; i < 2; i++)
      chk($sformatf("masked_mem_dut%0d", i), tbmem[i],
          32'h11BB33DD);

    hs_cyc.delete();
    win_seq.delete();
    for (int k = 0; k < 4; k++) begin
      wq0.push_back({$urandom, 4'b1111});
      wq1.push_back({$urandom, 4'b1111});
    end
    wait_idle("contention", 200);
    chk("contention_count", hs_cyc.size(), 8);
    for (int k = 0; k < win_seq.size(); k++)
      chk($sformatf("contention_grant%0d", k), win_seq[k], k % 2);
    for (int k = 1; k < hs_cyc.size(); k++)
      chk($sformatf("contention_gap%0d", k),
          hs_cyc[k] - hs_cyc[k-1], 5);

    clr_cnt = 1;
    wq0.push_back({32'h55667788, 4'b1111});
    wait_idle("clear_prio", 100);
    for (int i = 0; i < 2; i++)
      chk($sformatf("clear_prio_mem_dut%0d", i), tbmem[i],
          32'h55667788);

    wq0.push_back({32'hCAFEF00D, 4'b1111});
    @(hs_ev);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_outs_zero("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midop_mem_dut0", tbmem[0], 32'h5566770D);
    chk("midop_mem_dut1", tbmem[1], 32'hCA667788);
    win_seq.delete();
    wq0.push_back({32'h0BADCAFE, 4'b1111});
    wq1.push_back({32'h12345678, 4'b1111});
    wait_idle("post_reset_tie", 100);
    chk("post_reset_tie_count", win_seq.size(), 2);
    if (win_seq.size() == 2) begin
      chk("post_reset_tie_first", win_seq[0], 0);
      chk("post_reset_tie_second", win_seq[1], 1);
    end

    wq0.push_back({32'h01020304, 4'b1111});
    wait_idle("reverse", 100);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reverse_mem_dut%0d", i), tbmem[i],
          32'h01020304);

    wq1.push_back({32'hFFEEDDCC, 4'b0000});
    wait_idle("mask_zero", 100);
    for (int i = 0; i < 2; i++)
      chk($sformatf("mask_zero_mem_dut%0d", i), tbmem[i],
          32'h01020304);

    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 4);
      w.d = $urandom;
      w.m = 4'($urandom_range(0, 15));
      if (sel == 0 || sel == 2) wq0.push_back(w);
      w.d = $urandom;
      w.m = 4'($urandom_range(0, 15));
      if (sel == 1 || sel == 2) wq1.push_back(w);
      if (sel >= 3) clr_cnt++;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle("random", 3000);

    chk("final_rec_q0", expq0.size(), 0);
    chk("final_rec_q1", expq1.size(), 0);
    chk("final_mem_q0", memq0.size(), 0);
    chk("final_mem_q1", memq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
